// File: rtl/idst7_16_seq.sv
// idst7_16_seq: 16-point inverse DST-VII, four coefficients per cycle into 16 accumulators
module idst7_16_seq #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [15:0][IN_W-1:0]  in_coef,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [15:0][OUT_W-1:0] out_sample
);
  localparam int ACC_W = IN_W + 12;
  localparam logic [16:0][5:0] MAG = {6'd45, 6'd44, 6'd43, 6'd42, 6'd41, 6'd39, 6'd36, 6'd34,
                                      6'd31, 6'd28, 6'd24, 6'd20, 6'd17, 6'd13, 6'd8, 6'd4, 6'd0};
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  // sin(pi*m/33) folds onto the first 16 magnitudes; sign flips in the second half-period
  function automatic logic [7:0] kc(input int k, input int n);
    int m;
    m = ((2 * k + 1) * (n + 1)) % 66;
    return m <= 16 ? 8'(MAG[5'(m)]) : m <= 33 ? 8'(MAG[5'(33 - m)]) :
           m <= 49 ? -(8'(MAG[5'(m - 33)])) : -(8'(MAG[5'(66 - m)]));
  endfunction
  function automatic logic [255:0][7:0] gen_ct();
    logic [255:0][7:0] t;
    t = '0;
    for (int k = 0; k < 16; k++)
      for (int n = 0; n < 16; n++)
        t[8'(k * 16 + n)] = kc(k, n);
    return t;
  endfunction
  localparam logic [255:0][7:0] CT = gen_ct();
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  state_t state, nxt;
  logic [1:0] g;
  logic [15:0][IN_W-1:0] y;
  logic signed [ACC_W-1:0] acc [16];
  logic signed [ACC_W-1:0] sum [16];
  logic signed [ACC_W-1:0] sh [16];
  logic [15:0][OUT_W-1:0] sat;
  assign in_ready  = rst_n && state == IDLE;
  assign out_valid = state == OUT;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: accept in IDLE, four group cycles in CALC, hold in OUT until taken
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (in_valid ? CALC : IDLE) :
          state == CALC ? (g == 2'd3 ? OUT : CALC) :
          (out_ready ? IDLE : state);
  end
  // group g adds Y[4g..4g+3] times their kernel rows, then rounds and saturates the totals
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      sum[n] = acc[n];
      for (int j = 0; j < 4; j++)
        sum[n] = sum[n] + ACC_W'($signed(y[{g, 2'(j)}])) * ACC_W'($signed(CT[{g, 2'(j), 4'(n)}]));
      sh[n]  = (sum[n] + RND) >>> SHIFT;
      sat[n] = sh[n] > MAXV ? MAXV[OUT_W-1:0] : sh[n] < MINV ? MINV[OUT_W-1:0] : sh[n][OUT_W-1:0];
    end
  end
  // capture coefficients, accumulate per group, load outputs on the last group
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y          <= '0;
      acc        <= '{default: '0};
      g          <= '0;
      out_sample <= '0;
    end else if (in_valid && in_ready) begin
      y   <= in_coef;
      acc <= '{default: '0};
      g   <= '0;
    end else if (state == CALC) begin
      acc <= sum;
      g   <= g + 2'd1;
      if (g == 2'd3) out_sample <= sat;
    end
endmodule

// File: tb/tb_idst7_16_seq.sv
// tb_idst7_16_seq: scoreboard bench for the inverse 16-point DST-VII against a trig-derived model
module tb_idst7_16_seq;
  typedef logic [15:0][15:0] vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  vec_t in_coef = '0, out_sample;
  int checks = 0, failures = 0, cyc = 0;
  int cm [16][16];
  vec_t exp_q [$];
  int lat_q [$];
  bit rr_mode = 0, ready_force = 1, pv = 0;
  int e0 [16] = '{4, 8, 13, 17, 20, 24, 28, 31, 34, 36, 39, 41, 42, 43, 44, 45};
  int e5 [16] = '{39, 39, 0, -39, -39, 0, 39, 39, 0, -39, -39, 0, 39, 39, 0, -39};
  int ep [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  int en [16] = '{0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1, -1, -1};

  idst7_16_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) out_ready = rr_mode ? ($urandom_range(3) != 0) : ready_force;

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  function automatic vec_t mk(input int a [16]);
    vec_t r;
    for (int i = 0; i < 16; i++) r[i] = 16'(a[i]);
    return r;
  endfunction

  function automatic vec_t model(input vec_t y);
    vec_t r;
    longint s;
    for (int n = 0; n < 16; n++) begin
      s = 0;
      for (int k = 0; k < 16; k++) s += longint'(cm[k][n]) * longint'($signed(y[k]));
      s = longint'($rtoi($floor(real'(s) / 64.0 + 0.5)));
      s = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
      r[n] = 16'(s);
    end
    return r;
  endfunction

  function automatic vec_t forward(input int x [16]);
    vec_t r;
    longint s;
    for (int k = 0; k < 16; k++) begin
      s = 0;
      for (int n = 0; n < 16; n++) s += longint'(cm[k][n]) * longint'(x[n]);
      s = longint'($rtoi($floor(real'(s) / 4.0 + 0.5)));
      s = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
      r[k] = 16'(s);
    end
    return r;
  endfunction

  task automatic send(input vec_t v, input vec_t e);
    int t = 0;
    @(negedge clk);
    in_coef = v;
    in_valid = 1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else begin
      exp_q.push_back(e);
      lat_q.push_back(cyc + 1);
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // monitor: latency on each out_valid rise, sample vector on each transfer
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (out_valid && !pv) begin
        if (lat_q.size() == 0) chk("latency_unexpected", 1, 0);
        else chk("latency", cyc - lat_q.pop_front(), 4);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", out_sample, 0);
        else chk("sample", out_sample, exp_q.pop_front());
      end
    end
    pv = out_valid;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, held;
    int x [16];
    int t;
    for (int k = 0; k < 16; k++)
      for (int n = 0; n < 16; n++) begin
        real a;
        a = 256.0 / $sqrt(33.0) * $sin(3.141592653589793 * real'((2 * k + 1) * (n + 1)) / 33.0);
        cm[k][n] = a >= 0.0 ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
      end
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sample", out_sample, 0);
    rst_n = 1;
    #1 chk("post_reset_in_ready", in_ready, 1);
    v = '0; v[0] = 16'd64;  send(v, mk(e0));
    v = '0; v[5] = 16'd64;  send(v, mk(e5));
    v = '0; v[0] = 16'd1;   send(v, mk(ep));
    v = '0; v[0] = 16'hffff; send(v, mk(en));
    v = {16{16'h7fff}};     send(v, model(v));
    v = {16{16'h8000}};     send(v, model(v));
    drain();
    chk("sat_pos_x0", model({16{16'h7fff}}) & 256'hffff, 256'h7fff);
    rr_mode = 0;
    ready_force = 0;
    for (int i = 0; i < 16; i++) v[i] = 16'($urandom_range(65535));
    send(v, model(v));
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid", out_valid, 1);
    held = out_sample;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1;
      for (int j = 0; j < 16; j++) in_coef[j] = 16'($urandom_range(65535));
      #2;
      chk("bp_hold", out_sample, held);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    ready_force = 1;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_queue", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) v[i] = 16'($urandom_range(65535));
    send(v, model(v));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    exp_q.delete();
    lat_q.delete();
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_sample", out_sample, 0);
    chk("midreset_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    chk("midreset_no_output", out_valid, 0);
    v = '0; v[0] = 16'd64; send(v, mk(e0));
    drain();
    rr_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      for (int n = 0; n < 16; n++) x[n] = int'($urandom_range(511)) - 256;
      v = forward(x);
      send(v, model(v));
    end
    drain();
    rr_mode = 0;
    ready_force = 1;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
